// File: rtl/count_seg_display.sv
// count_seg_display: shows a 4-bit count (0-15) as two decimal digits on a
// 2-digit multiplexed common-anode seven-segment display. Digits are
// time-sliced with dark gaps between them to prevent ghosting. The shown
// value is only swapped at a frame boundary, so both digits of a frame
// always come from the same count.
module count_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       value_valid,
  input  logic       blank,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  // The slot counter must reach the longer of the two slot lengths minus one.
  localparam int MAX_LEN = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ONES  = 2'd0,
    GAP_O = 2'd1,
    TENS  = 2'd2,
    GAP_T = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] slot_cnt;
  logic [3:0]       pending;
  logic [3:0]       shadow;

  logic             slot_last;
  logic             tens;
  logic [3:0]       ones;
  logic [1:0]       an_next;
  logic [6:0]       seg_next;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  // Split the displayed value into a tens flag and a 0-9 ones digit.
  always_comb begin
    tens = (shadow >= 4'd10);
    ones = tens ? (shadow - 4'd10) : shadow;
  end

  // Flag the final cycle of the current slot; digit and gap slots differ in length.
  always_comb begin
    slot_last = 1'b0;
    case (state)
      ONES, TENS: slot_last = (slot_cnt == DIGIT_LAST);
      default:    slot_last = (slot_cnt == GAP_LAST);
    endcase
  end

  // Decode the anode/segment drive for the current slot; only one anode can ever be low.
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    if (!blank) begin
      case (state)
        ONES: begin
          an_next  = AN_ONES;
          seg_next = digit_pattern(ones);
        end
        TENS: begin
          if (tens) begin
            an_next  = AN_TENS;
            seg_next = digit_pattern(4'd1);
          end
        end
        default: begin
          an_next  = AN_OFF;
          seg_next = SEG_OFF;
        end
      endcase
    end
  end

  // Keep the most recent strobed count until the next frame picks it up.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 4'd0;
    end else if (value_valid) begin
      pending <= value;
    end
  end

  // Slot sequencer: ONES -> GAP_O -> TENS -> GAP_T, loading the shadow and outputs as it goes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= GAP_T;
      slot_cnt    <= '0;
      shadow      <= 4'd0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      seg         <= seg_next;
      frame_start <= 1'b0;
      if (slot_last) begin
        slot_cnt <= '0;
        case (state)
          ONES:  state <= GAP_O;
          GAP_O: state <= TENS;
          TENS:  state <= GAP_T;
          default: begin
            state       <= ONES;
            shadow      <= value_valid ? value : pending;
            frame_start <= 1'b1;
          end
        endcase
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_seg_display.sv
// tb_count_seg_display: self-checking bench for count_seg_display using a
// frame-position reference model and randomized stimulus.
module tb_count_seg_display;

  localparam int R = 4;
  localparam int G = 1;
  localparam int F = 2 * (R + G);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] value = 4'd0;
  logic       value_valid = 1'b0;
  logic       blank = 1'b0;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  count_seg_display #(
    .REFRESH_DIV(R),
    .GAP_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .value_valid(value_valid),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: edge index since reset release, the frame position and the captured counts.
  int         e_m = -1;
  int         pending_m = 0;
  int         shadow_m = 0;
  logic [1:0] exp_an = 2'b11;
  logic [6:0] exp_seg = 7'h7f;
  logic       exp_fs = 1'b0;

  // Which slot the display is in after post-reset edge e: 0 ones, 1 gap, 2 tens, 3 gap.
  function automatic int slot_of(input int e);
    int k;
    k = e - (G - 1);
    if (e < 0 || k < 0) return 3;
    k = k % F;
    if (k < R) return 0;
    if (k < R + G) return 1;
    if (k < 2 * R + G) return 2;
    return 3;
  endfunction

  function automatic bit is_boundary(input int e);
    int k;
    k = e - (G - 1);
    return (k >= 0) && ((k % F) == 0);
  endfunction

  function automatic logic [1:0] model_an(input int e, input int sh);
    case (slot_of(e))
      0:       return 2'b10;
      2:       return (sh >= 10) ? 2'b01 : 2'b11;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int e, input int sh);
    case (slot_of(e))
      0:       return pat[sh % 10];
      2:       return (sh >= 10) ? pat[sh / 10] : 7'h7f;
      default: return 7'h7f;
    endcase
  endfunction

  // Advance the model on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      e_m       <= -1;
      pending_m <= 0;
      shadow_m  <= 0;
      exp_an    <= 2'b11;
      exp_seg   <= 7'h7f;
      exp_fs    <= 1'b0;
    end else begin
      e_m     <= e_m + 1;
      exp_an  <= blank ? 2'b11 : model_an(e_m, shadow_m);
      exp_seg <= blank ? 7'h7f : model_seg(e_m, shadow_m);
      exp_fs  <= is_boundary(e_m + 1);
      if (is_boundary(e_m + 1)) shadow_m <= value_valid ? int'(value) : pending_m;
      if (value_valid) pending_m <= int'(value);
    end
  end

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic strobe(input logic [3:0] v);
    value = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; value = 4'd0; value_valid = 1'b0; blank = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7f) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: an=%b seg=%b, want an=11 seg=1111111", an, seg);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({an, seg, frame_start} !== {2'b11, 7'h7f, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_first_edge: an=%b seg=%b fs=%b, want 11 1111111 1", an, seg, frame_start);
    end
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      n_tests++;
      if ({an, seg, frame_start} !== {2'b10, 7'b1000000, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_ones: an=%b seg=%b fs=%b, want 10 1000000 0", an, seg, frame_start);
      end
    end
    for (int i = 0; i < G + R; i++) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7f) begin
        n_fail++;
        $display("[TB] FAIL reset_tens_suppressed: an=%b seg=%b, want 11 1111111", an, seg);
      end
    end
    @(negedge clk);
    n_tests++;
    if (an !== 2'b11 || frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_second_frame: an=%b fs=%b, want an=11 fs=1", an, frame_start);
    end
  endtask

  task automatic test_single_digit();
    bit ok;
    strobe(4'd7);
    wait_fs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL seven_frame_timeout: frame_start=0, want a pulse within %0d cycles", 2 * F);
    end
    for (int i = 0; i < 2 * (R + G) - 1; i++) begin
      @(negedge clk);
      n_tests++;
      if (an === 2'b00 || {an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
        n_fail++;
        $display("[TB] FAIL seven_model: an=%b seg=%b fs=%b, want %b %b %b", an, seg, frame_start, exp_an, exp_seg, exp_fs);
      end
      if (i < R) begin
        n_tests++;
        if (an !== 2'b10 || seg !== 7'b1111000) begin
          n_fail++;
          $display("[TB] FAIL seven_ones: an=%b seg=%b, want 10 1111000", an, seg);
        end
      end else if (i >= R + G && i < 2 * R + G) begin
        n_tests++;
        if (an !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL seven_tens_dark: an=%b, want 11", an);
        end
      end
    end
  endtask

  task automatic test_two_digit();
    bit ok;
    strobe(4'd12);
    wait_fs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL twelve_frame_timeout: frame_start=0, want a pulse");
    end
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'b0100100) begin
        n_fail++;
        $display("[TB] FAIL twelve_ones: an=%b seg=%b, want 10 0100100", an, seg);
      end
    end
    @(negedge clk);
    n_tests++;
    if (an !== 2'b11 || seg !== 7'h7f) begin
      n_fail++;
      $display("[TB] FAIL twelve_gap: an=%b seg=%b, want 11 1111111", an, seg);
    end
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b01 || seg !== 7'b1111001) begin
        n_fail++;
        $display("[TB] FAIL twelve_tens: an=%b seg=%b, want 01 1111001", an, seg);
      end
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    wait_fs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL tear_frame_timeout: frame_start=0, want a pulse");
    end
    repeat (R + G) @(negedge clk);
    value = 4'd15;
    value_valid = 1'b1;
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      value_valid = 1'b0;
      n_tests++;
      if (an !== 2'b01 || seg !== 7'b1111001) begin
        n_fail++;
        $display("[TB] FAIL tear_old_tens: an=%b seg=%b, want 01 1111001", an, seg);
      end
    end
    @(negedge clk);
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tear_boundary: fs=%b, want 1", frame_start);
    end
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'b0010010) begin
        n_fail++;
        $display("[TB] FAIL tear_new_ones: an=%b seg=%b, want 10 0010010", an, seg);
      end
    end
    repeat (G + R) @(negedge clk);
    value = 4'd3;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_boundary: fs=%b, want 1", frame_start);
    end
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      n_tests++;
      if (an !== 2'b10 || seg !== 7'b0110000) begin
        n_fail++;
        $display("[TB] FAIL same_cycle_ones: an=%b seg=%b, want 10 0110000", an, seg);
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    int fs_seen;
    strobe(4'd9);
    wait_fs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL blank_frame_timeout: frame_start=0, want a pulse");
    end
    blank = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) fs_seen++;
      n_tests++;
      if (an !== 2'b11 || seg !== 7'h7f) begin
        n_fail++;
        $display("[TB] FAIL blank_dark: an=%b seg=%b, want 11 1111111", an, seg);
      end
    end
    n_tests++;
    if (fs_seen != 2) begin
      n_fail++;
      $display("[TB] FAIL blank_frame_pulses: got %0d, want 2", fs_seen);
    end
    blank = 1'b0;
    @(negedge clk);
    n_tests++;
    if (an !== 2'b10 || seg !== 7'b0010000) begin
      n_fail++;
      $display("[TB] FAIL blank_release: an=%b seg=%b, want 10 0010000", an, seg);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    strobe(4'd15);
    wait_fs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL midreset_frame_timeout: frame_start=0, want a pulse");
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (an !== 2'b10 || seg !== 7'b0010010) begin
      n_fail++;
      $display("[TB] FAIL midreset_before: an=%b seg=%b, want 10 0010010", an, seg);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (an !== 2'b11 || seg !== 7'h7f) begin
      n_fail++;
      $display("[TB] FAIL midreset_dark: an=%b seg=%b, want 11 1111111", an, seg);
    end
    @(negedge clk);
    n_tests++;
    if (an !== 2'b11 || frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_restart: an=%b fs=%b, want 11 1", an, frame_start);
    end
    for (int i = 0; i < 2 * R + G; i++) begin
      @(negedge clk);
      n_tests++;
      if (i < R && (an !== 2'b10 || seg !== 7'b1000000)) begin
        n_fail++;
        $display("[TB] FAIL midreset_zero_ones: an=%b seg=%b, want 10 1000000", an, seg);
      end else if (i >= R && an !== 2'b11) begin
        n_fail++;
        $display("[TB] FAIL midreset_zero_tens: an=%b, want 11", an);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_tests++;
      if (an === 2'b00 || {an, seg, frame_start} !== {exp_an, exp_seg, exp_fs}) begin
        n_fail++;
        $display("[TB] FAIL random_model cycle %0d: an=%b seg=%b fs=%b, want %b %b %b",
                 i, an, seg, frame_start, exp_an, exp_seg, exp_fs);
      end
      value       = 4'($urandom_range(0, 15));
      value_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      reset       = ($urandom_range(0, 79) == 0);
    end
    reset = 1'b0;
    blank = 1'b0;
    value_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_two_digit();
    test_tear_free();
    test_blank();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
- Downstream consumer of the 4-bit up counter.
- Converts the counter value (0-15) into two decimal digits, tens and ones.
- Drives a 2-digit multiplexed common-anode seven-segment display: time-sliced digit scanning, anti-ghosting dead time between digits, and tear-free value updates.
- Sits between the counter output and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per slot; legal range >= 2.
- GAP_CYCLES, 16, clock cycles with all anodes off between digit slots; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4  count to display; unsigned 0-15.
- value_valid  input  1  capture strobe for value; single- or multi-cycle.
- blank  input  1  when high, all digits are dark; scanning continues.
- an  output  2  anode enables, active-low; an[0] = ones digit, an[1] = tens digit.
- seg  output  7  segment drive, active-low, ordered {g,f,e,d,c,b,a}.
- frame_start  output  1  one-cycle pulse when a new display frame begins, i.e. when shadow is loaded.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. No other resets and no clock gating.
- Registers:
  - pending[3:0]: latest captured value.
  - shadow[3:0]: value currently being displayed.
  - state: 2 bits.
  - slot_cnt: wide enough to hold max(REFRESH_DIV, GAP_CYCLES) - 1.
  - an, seg and frame_start are registered outputs.
- Reset values: state = GAP_T, slot_cnt = 0, pending = 0, shadow = 0, an = 2'b11, seg = 7'b1111111, frame_start = 0. A reset asserted mid-frame takes effect on the next edge and aborts the frame; there is no partial-state carryover.
- Capture: pending <= value on every cycle with value_valid = 1. Otherwise pending holds.
- FSM states and transitions, repeating forever: ONES -> GAP_O -> TENS -> GAP_T -> ONES.
  - ONES and TENS last REFRESH_DIV cycles.
  - GAP_O and GAP_T last GAP_CYCLES cycles.
  - slot_cnt counts from 0 to the state's length - 1. On the terminal count, the FSM advances and slot_cnt is cleared to 0.
  - Frame length = 2*(REFRESH_DIV + GAP_CYCLES) cycles.
- Frame boundary (GAP_T -> ONES transition):
  - shadow <= value_valid ? value : pending. A same-cycle strobe wins.
  - frame_start = 1 for that one cycle.
  - shadow changes only at this boundary, so the two digits of one frame always come from the same value.
- Digit math on shadow:
  - tens = (shadow >= 10) ? 1 : 0.
  - ones = shadow - 10*tens, giving a range of 0-9.
  - No other arithmetic. The input is 4 bits, so there is no overflow case.
- Output latency: an and seg are registered from the current state and shadow. They reflect a state one cycle after the FSM enters it.
- Output decode:
  - ONES: an = 2'b10, seg = pattern(ones).
  - TENS: if tens = 1, an = 2'b01 and seg = pattern(1). If tens = 0, apply leading-zero suppression: an = 2'b11, seg = 7'b1111111.
  - GAP_O and GAP_T: an = 2'b11, seg = 7'b1111111.
  - blank = 1: an = 2'b11 and seg = 7'b1111111 regardless of state. The FSM, captures and frame_start are unaffected.
- Segment patterns (active-low {g..a}): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Invariant: an is never 2'b00. At most one digit is lit, on any cycle, including reset and parameter extremes.
- Wrap-around: when the counter goes 15 -> 0, the display goes from "15" to " 0" (tens suppressed) at the next frame boundary.

Test Plan (REFRESH_DIV=4, GAP_CYCLES=1; frame = 10 cycles):
1. Reset held 3 cycles, then released with value=0 and no strobe:
   - During reset and the first cycle after: an=11, seg=1111111.
   - frame_start pulses on the first post-reset edge.
   - Next 4 cycles: an=10, seg=1000000.
   - TENS slot: an=11 (zero suppressed).
2. value=7 with a strobe, then wait for frame_start:
   - ONES slot: an=10, seg=1111000.
   - TENS slot: an=11 for all 4 cycles.
   - an is never 00 at any cycle.
3. value=12 with a strobe:
   - ONES slot: an=10, seg=0100100.
   - TENS slot: an=01, seg=1111001.
   - Exactly 1 gap cycle with an=11 between slots.
4. Strobe value=15 during a TENS slot while 12 is displayed:
   - The rest of that frame still shows "12".
   - The next frame shows "15" (seg=0010010 in ONES).
   - A strobe of 3 coinciding with the frame_start cycle displays "3" in that same frame.
5. Hold blank=1 for 2 full frames while 9 is shown:
   - an=11 throughout.
   - frame_start still pulses every 10 cycles.
   - After blank is deasserted, digit 9 (seg=0010000) returns with 1 cycle of latency.
6. Assert reset for 1 cycle mid-ONES slot with "15" shown:
   - The next cycle has an=11 and seg=1111111.
   - The display then restarts showing " 0" until a new strobe arrives.
